// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect sequencer: walks {note, dur} steps from a constant ROM.
// Build option: define SFX_GAP_EN to end every step longer than one tick with one silent tick.
module sfx_sequencer #(
  parameter int NOTE_W  = 5,
  parameter int LEN_W   = 7,
  parameter int NUM_SFX = 3,
  parameter int ROM_AW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_SFX-1:0] trig,
  output logic [NOTE_W-1:0]  note,
  output logic               busy,
  output logic [2:0]         active_id,
  output logic               done
);
  localparam int STEP_W = NOTE_W + LEN_W;

`ifdef SFX_GAP_EN
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

  state_t            state_q;
  logic [2:0]        id_q;
  logic [ROM_AW-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [NOTE_W-1:0] note_q;
  logic              busy_q;
  logic              done_q;

  function automatic logic [STEP_W-1:0] mk_step(input int n, input int d);
    return {NOTE_W'(n), LEN_W'(d)};
  endfunction

  // Script table; any address not listed reads as END (dur = 0).
  function automatic logic [STEP_W-1:0] rom_rd(input logic [ROM_AW-1:0] a);
    logic [STEP_W-1:0] s;
    s = '0;
    case (int'(a))
      0:  s = mk_step(18, 9);
      1:  s = mk_step(19, 40);
      3:  s = mk_step(1, 19);
      5:  s = mk_step(12, 15);
      6:  s = mk_step(0, 1);
      7:  s = mk_step(17, 15);
      8:  s = mk_step(0, 16);
      9:  s = mk_step(17, 15);
      10: s = mk_step(0, 1);
      11: s = mk_step(16, 15);
      12: s = mk_step(0, 1);
      13: s = mk_step(15, 15);
      14: s = mk_step(0, 1);
      15: s = mk_step(13, 16);
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [ROM_AW-1:0] start_addr(input logic [2:0] id);
    logic [ROM_AW-1:0] a;
    case (id)
      3'd0:    a = ROM_AW'(0);
      3'd1:    a = ROM_AW'(3);
      3'd2:    a = ROM_AW'(5);
      default: a = ROM_AW'(2);
    endcase
    return a;
  endfunction

  logic              trig_any;
  logic [2:0]        trig_id;
  logic              accept;
  logic [STEP_W-1:0] step;
  logic [NOTE_W-1:0] step_note;
  logic [LEN_W-1:0]  step_dur;

  always_comb begin
    trig_any = 1'b0;
    trig_id  = 3'd0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (trig[i]) begin
        trig_any = 1'b1;
        trig_id  = 3'(i);
      end
    end
  end

  // Equal index restarts the running effect; a lower one is dropped.
  assign accept    = trig_any && ((state_q == IDLE) || (trig_id >= id_q));
  assign step      = rom_rd(addr_q);
  assign step_note = step[STEP_W-1:LEN_W];
  assign step_dur  = step[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
      addr_q  <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= LOAD;
        id_q    <= trig_id;
        addr_q  <= start_addr(trig_id);
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          LOAD: begin
            if (step_dur == '0) begin
              state_q <= IDLE;
              id_q    <= 3'd0;
              note_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              note_q  <= step_note;
              cnt_q   <= step_dur;
              state_q <= PLAY;
            end
          end
          PLAY: begin
            if (tick) begin
              cnt_q <= cnt_q - LEN_W'(1);
              if (cnt_q == LEN_W'(1)) begin
                addr_q  <= addr_q + ROM_AW'(1);
                state_q <= LOAD;
              end
`ifdef SFX_GAP_EN
              else if (cnt_q == LEN_W'(2)) begin
                note_q  <= '0;
                state_q <= GAP;
              end
`endif
            end
          end
`ifdef SFX_GAP_EN
          GAP: begin
            if (tick) begin
              addr_q  <= addr_q + ROM_AW'(1);
              state_q <= LOAD;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign note      = note_q;
  assign busy      = busy_q;
  assign active_id = id_q;
  assign done      = done_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: expected output changes come from a script-level timing model.
// Honours SFX_GAP_EN when the design is built with it.
module tb_sfx_sequencer;
  localparam int MAXE = 40000;
  localparam int WIN  = 1400;
`ifdef SFX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int N0[2]  = '{18, 19};
  localparam int D0[2]  = '{9, 40};
  localparam int N1[1]  = '{1};
  localparam int D1[1]  = '{19};
  localparam int N2[11] = '{12, 0, 17, 0, 17, 0, 16, 0, 15, 0, 13};
  localparam int D2[11] = '{15, 1, 15, 16, 15, 1, 15, 1, 15, 1, 16};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] trig = 3'd0;
  logic [4:0] note;
  logic       busy;
  logic [2:0] active_id;
  logic       done;

  sfx_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .trig(trig),
    .note(note), .busy(busy), .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  // Tuple layout: {note[4:0], busy, active_id[2:0], done}
  typedef struct {
    int         e;
    logic [9:0] t;
  } ev_t;

  ev_t        exp_q[$];
  logic [9:0] exp_t [MAXE];
  logic [2:0] in_trig [MAXE];
  bit         in_rst [MAXE];
  int         sc_off[$];
  logic [2:0] sc_vec[$];   // vector 0 stands for a reset event

  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  int         tp = 1;
  int         tph = 0;
  int         cur_e = 1;
  bit         fin_req = 1'b0;
  bit         fin_done = 1'b0;
  logic [9:0] last_t = '0;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    logic [9:0] cur;
    ev_t        ev;
    cur = {note, busy, active_id, done};
    if (edge_n == 3) begin
      checks++;
      if (cur !== 10'd0) begin
        errors++;
        $display("FAIL reset_state got note=%0d busy=%b id=%0d done=%b, required all zero",
                 note, busy, active_id, done);
      end
      last_t = '0;
    end else if (edge_n > 3 && cur !== last_t) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output edge=%0d got note=%0d busy=%b id=%0d done=%b, required no change",
                 edge_n, note, busy, active_id, done);
      end else begin
        ev = exp_q.pop_front();
        if (ev.e != edge_n || ev.t !== cur) begin
          errors++;
          $display("FAIL output_event got edge=%0d note=%0d busy=%b id=%0d done=%b, required edge=%0d note=%0d busy=%b id=%0d done=%b",
                   edge_n, note, busy, active_id, done,
                   ev.e, ev.t[9:5], ev.t[4], ev.t[3:1], ev.t[0]);
        end
      end
      last_t = cur;
    end
    if (fin_req && !fin_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
      end
      fin_done = 1'b1;
    end
  end

  function automatic int first_tick(input int s);
    return s + ((tph - (s % tp)) + tp) % tp;
  endfunction

  function automatic void get_step(input int id, input int k, output int n, output int d);
    case (id)
      0:       begin n = N0[k]; d = D0[k]; end
      1:       begin n = N1[k]; d = D1[k]; end
      default: begin n = N2[k]; d = D2[k]; end
    endcase
  endfunction

  task automatic clear_from(input int a, input int b);
    for (int x = a; x <= b && x < MAXE; x++) exp_t[x] = '0;
  endtask

  // Effect accepted at edge e0: one LOAD edge, then each step holds for dur ticks plus a LOAD edge.
  task automatic play(input int id, input int e0);
    int e, n, d, nst, t_first, t_end, t_gap;
    exp_t[e0] = {exp_t[e0-1][9:5], 1'b1, 3'(id), 1'b0};
    e   = e0 + 1;
    nst = (id == 0) ? 2 : (id == 1) ? 1 : 11;
    for (int k = 0; k < nst; k++) begin
      get_step(id, k, n, d);
      t_first = first_tick(e + 1);
      t_end   = t_first + (d - 1) * tp;
      t_gap   = (GAP_EN && d > 1) ? t_first + (d - 2) * tp : t_end + 1;
      for (int x = e; x <= t_end && x < MAXE; x++)
        exp_t[x] = {(x >= t_gap) ? 5'd0 : 5'(n), 1'b1, 3'(id), 1'b0};
      e = t_end + 1;
    end
    if (e < MAXE) exp_t[e] = {5'd0, 1'b0, 3'd0, 1'b1};
  endtask

  task automatic run_scn(input string name, input int p, input int phv);
    int s, wend, ea, win;
    s = cur_e;
    tp = p;
    tph = phv;
    exp_t[s-1] = '0;
    for (int e = s; e <= s + WIN; e++) begin
      exp_t[e] = '0;
      in_trig[e] = 3'd0;
      in_rst[e] = 1'b0;
    end
    wend = s;
    for (int i = 0; i < sc_off.size(); i++) begin
      ea = s + sc_off[i];
      wend = ea;
      if (sc_vec[i] == 3'd0) begin
        in_rst[ea] = 1'b1;
        clear_from(ea, s + WIN);
      end else begin
        in_trig[ea] = sc_vec[i];
        win = sc_vec[i][2] ? 2 : (sc_vec[i][1] ? 1 : 0);
        if (!exp_t[ea-1][4] || win >= int'(exp_t[ea-1][3:1])) begin
          clear_from(ea, s + WIN);
          play(win, ea);
        end
      end
    end
    for (int e = s; e <= s + WIN; e++) if (exp_t[e] != '0 && e > wend) wend = e;
    wend = wend + 3;
    for (int e = s; e <= wend; e++) begin
      if (exp_t[e] !== exp_t[e-1]) exp_q.push_back('{e: e, t: exp_t[e]});
    end
    for (int e = s; e <= wend; e++) begin
      tick = ((e % tp) == tph);
      trig = in_trig[e];
      rst  = in_rst[e];
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
    trig = 3'd0;
    rst  = 1'b0;
    $display("scenario %-9s tick_period=%0d events=%0d edges %0d..%0d", name, p, sc_off.size(), s, wend);
    cur_e = wend + 1;
    sc_off.delete();
    sc_vec.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cur_e = 4;

    sc_off.push_back(2);  sc_vec.push_back(3'b001);
    run_scn("hit", 4, 0);
    sc_off.push_back(2);  sc_vec.push_back(3'b011);
    run_scn("simul", 2, 1);
    sc_off.push_back(2);  sc_vec.push_back(3'b001);
    sc_off.push_back(22); sc_vec.push_back(3'b100);
    run_scn("preempt", 4, 0);
    sc_off.push_back(2);  sc_vec.push_back(3'b100);
    sc_off.push_back(30); sc_vec.push_back(3'b010);
    run_scn("drop", 3, 2);
    sc_off.push_back(2);  sc_vec.push_back(3'b100);
    sc_off.push_back(82); sc_vec.push_back(3'b000);
    run_scn("reset", 4, 0);
    sc_off.push_back(2);  sc_vec.push_back(3'b001);
    run_scn("ticktrig", 1, 0);
    sc_off.push_back(2);  sc_vec.push_back(3'b100);
    sc_off.push_back(40); sc_vec.push_back(3'b100);
    run_scn("restart", 2, 0);

    for (int r = 0; r < 25 && cur_e + WIN + 8 < MAXE; r++) begin
      int kind, off, p;
      kind = int'($urandom_range(0, 3));
      p    = int'($urandom_range(1, 4));
      off  = 2;
      sc_off.push_back(off);
      sc_vec.push_back(3'($urandom_range(1, 7)));
      if (kind == 1) begin
        off += int'($urandom_range(2, 150));
        sc_off.push_back(off);
        sc_vec.push_back(3'($urandom_range(1, 7)));
      end else if (kind == 2) begin
        off += int'($urandom_range(2, 200));
        sc_off.push_back(off);
        sc_vec.push_back(3'd0);
      end else if (kind == 3) begin
        repeat (2) begin
          off += int'($urandom_range(2, 120));
          sc_off.push_back(off);
          sc_vec.push_back(3'($urandom_range(1, 7)));
        end
      end
      run_scn("random", p, int'($urandom_range(0, p - 1)));
    end

    fin_req = 1'b1;
    repeat (4) @(posedge clk);
    if (!fin_done) $fatal(1, "FAIL final_check monitor did not respond");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Parametrised sound-effect sequencer for the game audio path. It replaces hard-coded per-effect note branches with a step ROM holding {note, duration} pairs. It arbitrates NUM_SFX trigger inputs by priority and drives a note code to the existing tone generator. Everything runs on one clock; a tick enable replaces the separate slow clock.

Parameters:
NOTE_W, 5, width of note code; 0 = silence
LEN_W, 7, width of step duration field, in ticks
NUM_SFX, 3, number of effects/trigger inputs (1..8); higher index = higher priority
ROM_AW, 5, step ROM address width (max 2**ROM_AW steps)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-clk step-time enable (note-length time base)
trig  in  NUM_SFX  one-clk start pulses, one bit per effect
note  out  NOTE_W  note code to tone generator
busy  out  1  high while an effect plays
active_id  out  3  index of playing effect (0 when idle)
done  out  1  one-clk pulse when an effect finishes naturally

Behaviour:
- Reset (clk edge with rst=1): note=0, busy=0, active_id=0, done=0, FSM=IDLE, step counter=0. rst wins over every other input, including mid-effect.
- Step ROM: internal constant case table of {note[NOTE_W], dur[LEN_W]}. A step with dur=0 terminates the script. Effect start addresses come from a constant table indexed by effect id.
- Default contents: effect0 (hit) = {18,9},{19,40},END. effect1 (fault) = {1,19},END. effect2 (lose) = {12,15},{0,1},{17,15},{0,16},{17,15},{0,1},{16,15},{0,1},{15,15},{0,1},{13,16},END.
- Arbitration: the highest set trig bit wins. It is accepted in IDLE. It is accepted while busy if its index >= active_id, which restarts the same effect or preempts a lower one. A lower-priority trig while busy is dropped.
- FSM states: IDLE, LOAD, PLAY, (GAP with feature).
- IDLE -> LOAD on an accepted trig: latch id, set addr=start[id], busy=1.
- LOAD (1 clk): read ROM[addr]. If dur=0, go to IDLE with done=1. Otherwise note<=step.note, cnt<=step.dur, go to PLAY.
- PLAY: on each tick, cnt decrements. On a tick with cnt==1, addr increments and the FSM goes to LOAD.
- Latency: trig at edge n -> busy=1 at n+1, note valid at n+2, independent of tick.
- Step length is exactly dur ticks, plus 1 clk for LOAD.
- An accepted trig in any state aborts the current script immediately and goes to LOAD next edge with the new id. It produces no done pulse.
- Script end: note=0, busy=0, active_id=0 on the same edge as done=1.
- addr wraps modulo 2**ROM_AW. A ROM without END is a table error, and the wrap is the defined behaviour.
- tick is ignored in IDLE and LOAD. tick and trig on the same edge: trig wins and the tick is not counted.

Optional Feature:
SFX_GAP_EN
- Defined: after each step whose dur>1, the FSM enters GAP for one tick with note=0 before LOAD. This gives audible articulation between repeated notes without explicit {0,1} ROM steps. Step's sounding time becomes dur-1 ticks plus 1 silent tick, so total step time is unchanged.
- Undefined: GAP state and its logic are absent; the next step's note follows directly.

Test Plan:
- Reset mid-effect: start effect2, assert rst at tick 20 -> next edge note=0, busy=0, done=0, active_id=0; no further output without trig.
- Hit script: pulse trig=3'b001, tick every 4 clk -> note=18 two clk later for 9 ticks, then 19 for 40 ticks, then done=1 for 1 clk, note=0, busy=0.
- Preemption: trig[0], then trig[2] at tick 5 -> note=12 two clk later, active_id=2, no done for effect0.
- Low-priority drop: effect2 playing, pulse trig[1] -> ignored; the effect2 sequence and its done timing are unchanged.
- Simultaneous triggers: trig=3'b011 from IDLE -> effect1 plays, note=1 for 19 ticks.
- Same edge tick+trig: from IDLE -> first step still lasts a full dur ticks. With SFX_GAP_EN: hit -> 18 for 8 ticks, 0 for 1, 19 for 39, 0 for 1, done.
